mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 127 ++++++++++++
 tb/tb_mem_access_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls upstream while
// waiting for dmem_ready, gives up after TIMEOUT cycles, and registers results for WB.
module mem_access_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwrite_mem,
    input  logic             memtoreg_mem,
    input  logic             memwrite_mem,
    input  logic [WIDTH-1:0] aluout_mem,
    input  logic [WIDTH-1:0] writedata_mem,
    input  logic [4:0]       regaddr_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic             mem_stall,
    output logic             regwrite_wb,
    output logic             memtoreg_wb,
    output logic [WIDTH-1:0] readdata_wb,
    output logic [WIDTH-1:0] aluout_wb,
    output logic [4:0]       regaddr_wb,
    output logic             misalign_err,
    output logic             bus_err
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          is_mem, is_store, misaligned, mem_ok;
    logic          req, stall, timeout;

    assign is_mem     = memtoreg_mem | memwrite_mem;
    assign is_store   = memwrite_mem;
    assign misaligned = is_mem & (aluout_mem[1:0] != 2'b00);
    assign mem_ok     = is_mem & (aluout_mem[1:0] == 2'b00);

    assign dmem_we    = memwrite_mem;
    assign dmem_addr  = aluout_mem;
    assign dmem_wdata = writedata_mem;

    // Gated by reset so the request drops the instant reset asserts, even with an op presented.
    assign dmem_req  = rst & req;
    assign mem_stall = rst & stall;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req        = 1'b0;
        stall      = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_ok) begin
                    req = 1'b1;
                    if (!dmem_ready) begin
                        stall      = 1'b1;
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ready) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1 this cycle: abandon the access.
                    timeout    = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            readdata_wb  <= '0;
            aluout_wb    <= '0;
            regaddr_wb   <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else if (stall) begin
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else if (timeout) begin
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b1;
        end else begin
            regwrite_wb  <= regwrite_mem & ~is_store & ~misaligned;
            memtoreg_wb  <= memtoreg_mem & ~is_store;
            if (is_mem && !is_store)
                readdata_wb <= dmem_rdata;
            aluout_wb    <= aluout_mem;
            regaddr_wb   <= regaddr_mem;
            misalign_err <= misaligned;
            bus_err      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed checks of mem_access_stage against a transaction-level
// model: each op is described by its type, address and ready latency.
module tb_mem_access_stage;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             regwrite_mem, memtoreg_mem, memwrite_mem;
    logic [WIDTH-1:0] aluout_mem, writedata_mem;
    logic [4:0]       regaddr_mem;
    logic             dmem_req, dmem_we;
    logic [WIDTH-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic             dmem_ready;
    logic             mem_stall;
    logic             regwrite_wb, memtoreg_wb;
    logic [WIDTH-1:0] readdata_wb, aluout_wb;
    logic [4:0]       regaddr_wb;
    logic             misalign_err, bus_err;

    int tests = 0;
    int fails = 0;

    // Expected WB state; *_known cleared where the stage's held value is not pinned down.
    logic             exp_rw, exp_mtr, exp_mis, exp_bus;
    logic [WIDTH-1:0] exp_rd, exp_alu;
    logic [4:0]       exp_ra;
    bit               rd_known, fields_known;

    mem_access_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
        .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .regaddr_mem(regaddr_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
        .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb), .readdata_wb(readdata_wb),
        .aluout_wb(aluout_wb), .regaddr_wb(regaddr_wb),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // One memory-stage transaction: ready rises after lat not-ready cycles.
    task automatic run_op(input string name, input bit rw, input bit mtr, input bit mw,
                          input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                          input logic [4:0] ra, input logic [WIDTH-1:0] rdata, input int lat);
        bit is_mem, aligned, exp_req, exp_stall, tmo, done;
        int req_cycles;
        is_mem  = mtr | mw;
        aligned = (addr[1:0] == 2'b00);
        regwrite_mem = rw; memtoreg_mem = mtr; memwrite_mem = mw;
        aluout_mem = addr; writedata_mem = wdata; regaddr_mem = ra;
        done = 0; req_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            dmem_ready = (i >= lat);
            dmem_rdata = (i >= lat) ? rdata : $urandom;
            @(negedge clk);
            exp_req   = is_mem && aligned;
            exp_stall = exp_req && (i < lat) && (i < TIMEOUT - 1);
            tmo       = exp_req && (i < lat) && (i == TIMEOUT - 1);
            if (dmem_req) req_cycles++;
            tests++;
            if (dmem_req !== exp_req || mem_stall !== exp_stall) begin
                fails++;
                $display("FAIL %s cyc%0d req/stall: got %b%b expected %b%b", name, i,
                         dmem_req, mem_stall, exp_req, exp_stall);
            end
            tests++;
            if (dmem_we !== mw || dmem_addr !== addr || dmem_wdata !== wdata) begin
                fails++;
                $display("FAIL %s cyc%0d bus: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                         name, i, dmem_we, dmem_addr, dmem_wdata, mw, addr, wdata);
            end
            @(posedge clk); #1;
            if (exp_stall) begin
                exp_rw = 0; exp_mtr = 0; exp_mis = 0; exp_bus = 0;
            end else if (tmo) begin
                exp_rw = 0; exp_mtr = 0; exp_mis = 0; exp_bus = 1;
                fields_known = 0; rd_known = 0;
                done = 1;
            end else begin
                exp_rw  = rw & !mw & !(is_mem && !aligned);
                exp_mtr = mtr & !mw;
                exp_mis = is_mem && !aligned;
                exp_bus = 0;
                if (is_mem && !mw) begin
                    exp_rd = rdata;
                    rd_known = aligned;
                end
                exp_alu = addr; exp_ra = ra; fields_known = 1;
                done = 1;
            end
            tests++;
            if (regwrite_wb !== exp_rw || memtoreg_wb !== exp_mtr ||
                misalign_err !== exp_mis || bus_err !== exp_bus) begin
                fails++;
                $display("FAIL %s cyc%0d wb ctl: got rw=%b mtr=%b mis=%b bus=%b expected rw=%b mtr=%b mis=%b bus=%b",
                         name, i, regwrite_wb, memtoreg_wb, misalign_err, bus_err,
                         exp_rw, exp_mtr, exp_mis, exp_bus);
            end
            if (fields_known) begin
                tests++;
                if (aluout_wb !== exp_alu || regaddr_wb !== exp_ra) begin
                    fails++;
                    $display("FAIL %s cyc%0d wb fields: got alu=%h ra=%0d expected alu=%h ra=%0d",
                             name, i, aluout_wb, regaddr_wb, exp_alu, exp_ra);
                end
            end
            if (rd_known) begin
                tests++;
                if (readdata_wb !== exp_rd) begin
                    fails++;
                    $display("FAIL %s cyc%0d readdata_wb: got %h expected %h", name, i, readdata_wb, exp_rd);
                end
            end
        end
        if (!done) begin
            fails++;
            $display("FAIL %s never completed: got no completion expected one within 40 cycles", name);
        end
        if (is_mem && aligned) begin
            tests++;
            if (req_cycles != ((lat < TIMEOUT) ? lat + 1 : TIMEOUT)) begin
                fails++;
                $display("FAIL %s req cycles: got %0d expected %0d", name, req_cycles,
                         (lat < TIMEOUT) ? lat + 1 : TIMEOUT);
            end
        end
        $display("[TB] %s rw=%b mtr=%b mw=%b addr=%h lat=%0d", name, rw, mtr, mw, addr, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        regwrite_mem = 0; memtoreg_mem = 1; memwrite_mem = 0;
        aluout_mem = 32'h40; writedata_mem = 0; regaddr_mem = 0;
        dmem_ready = 0; dmem_rdata = 0;
        #1;
        tests++;
        if ({regwrite_wb, memtoreg_wb, readdata_wb, aluout_wb, regaddr_wb, misalign_err, bus_err} !== '0
            || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got req=%b stall=%b alu=%h expected all zero", dmem_req, mem_stall, aluout_wb);
        end
        exp_rw = 0; exp_mtr = 0; exp_mis = 0; exp_bus = 0;
        exp_rd = 0; exp_alu = 0; exp_ra = 0; rd_known = 1; fields_known = 1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_directed();
        run_op("load_zero_wait", 1, 1, 0, 32'h100, 0, 5'd4, 32'hDEADBEEF, 0);
        run_op("store_3_wait", 1, 0, 1, 32'h200, 32'h55, 5'd6, 32'h0, 3);
        run_op("load_misalign", 1, 1, 0, 32'h102, 0, 5'd7, 32'h1234, 0);
        run_op("load_timeout", 1, 1, 0, 32'h300, 0, 5'd8, 32'h0, 1000);
        run_op("load_last_chance", 1, 1, 0, 32'h304, 0, 5'd9, 32'hCAFEF00D, TIMEOUT - 1);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_load", 1, 1, 0, 32'h400, 0, 5'd10, 32'h0BADF00D, 0);
        run_op("b2b_alu", 1, 0, 0, 32'h11, 0, 5'd11, 32'h0, 0);
    endtask

    task automatic test_reset_in_wait();
        regwrite_mem = 1; memtoreg_mem = 1; memwrite_mem = 0;
        aluout_mem = 32'h500; regaddr_mem = 5'd12; dmem_ready = 0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        tests++;
        if (dmem_req !== 1'b0 || {regwrite_wb, memtoreg_wb, readdata_wb, aluout_wb, regaddr_wb,
                                  misalign_err, bus_err} !== '0) begin
            fails++;
            $display("FAIL reset_in_wait: got req=%b rw=%b alu=%h expected req=0 and WB zero",
                     dmem_req, regwrite_wb, aluout_wb);
        end
        regwrite_mem = 1; memtoreg_mem = 0; memwrite_mem = 0;
        aluout_mem = 32'h7; regaddr_mem = 5'd3;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (aluout_wb !== 32'h7 || regaddr_wb !== 5'd3 || regwrite_wb !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_alu: got alu=%h ra=%0d rw=%b expected alu=7 ra=3 rw=1",
                     aluout_wb, regaddr_wb, regwrite_wb);
        end
        exp_rw = 1; exp_mtr = 0; exp_mis = 0; exp_bus = 0;
        exp_alu = 32'h7; exp_ra = 5'd3; exp_rd = 0; rd_known = 1; fields_known = 1;
        $display("[TB] reset during WAIT then ALU op");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, lat, pick;
            logic [WIDTH-1:0] addr;
            kind = $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            pick = $urandom_range(0, 9);
            lat  = (pick < 5) ? 0 : (pick < 8) ? $urandom_range(1, 5) :
                   (pick == 8) ? $urandom_range(TIMEOUT - 2, TIMEOUT) : 1000;
            run_op("random", $urandom_range(0, 1), kind == 1 || (kind == 2 && $urandom_range(0, 1) == 1),
                   kind == 2, addr, $urandom, 5'($urandom), $urandom, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
